// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster generator.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [9:0] pix_coord_t;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } tg_state_e;

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register for sync signals; every stage resets to 1 (inactive).
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '1;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster/sync generator: DrawX/DrawY/blank plus delayed hs/vs.
// Optional 8-bit frame counter output when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_DLY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output pix_coord_t DrawX,
    output pix_coord_t DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_start,
    output tg_state_e  state_dbg
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024) begin : g_err_h
            $error("vga_timing_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_err_v
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
        if (SYNC_DLY < 0 || SYNC_DLY > 3) begin : g_err_d
            $error("vga_timing_gen: SYNC_DLY must be 0..3");
        end
    endgenerate

    localparam pix_coord_t H_LAST  = pix_coord_t'(H_TOTAL - 1);
    localparam pix_coord_t V_LAST  = pix_coord_t'(V_TOTAL - 1);
    localparam pix_coord_t H_ACT_C = pix_coord_t'(H_ACTIVE);
    localparam pix_coord_t V_ACT_C = pix_coord_t'(V_ACTIVE);
    localparam pix_coord_t HS_BEG  = pix_coord_t'(H_ACTIVE + H_FP);
    localparam pix_coord_t HS_END  = pix_coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam pix_coord_t VS_BEG  = pix_coord_t'(V_ACTIVE + V_FP);
    localparam pix_coord_t VS_END  = pix_coord_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0] state;
    pix_coord_t hc, vc;
    pix_coord_t hc_nxt, vc_nxt;
    logic       hs_raw, vs_raw;

    // In HOLD the next count is forced to (0,0) so the first edge shows pixel (0,0).
    always_comb begin
        hc_nxt = '0;
        vc_nxt = '0;
        if (state != S_HOLD) begin
            if (hc == H_LAST) begin
                hc_nxt = '0;
                vc_nxt = (vc == V_LAST) ? '0 : vc + pix_coord_t'(1);
            end else begin
                hc_nxt = hc + pix_coord_t'(1);
                vc_nxt = vc;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_HOLD;
            hc          <= '0;
            vc          <= '0;
            blank       <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            case (state)
                S_HOLD:  state <= S_START;
                S_START: state <= S_RUN;
                default: state <= S_RUN;
            endcase
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            blank       <= (hc_nxt < H_ACT_C) && (vc_nxt < V_ACT_C);
            hs_raw      <= !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
            vs_raw      <= !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
            frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
            line_start  <= (hc_nxt == '0);
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // The START-cycle frame_start does not count, so the first frame reads 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 8'd0;
        end else if (state != S_HOLD && hc_nxt == '0 && vc_nxt == '0) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

    sync_delay_line #(
        .DEPTH (SYNC_DLY),
        .WIDTH (2)
    ) u_sync_dly (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       ({hs_raw, vs_raw}),
        .q       ({hs, vs})
    );

    assign DrawX     = hc;
    assign DrawY     = vc;
    assign state_dbg = tg_state_e'(state);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line checks, reduced-timing instance for frame checks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic vga_clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 vga_clk = ~vga_clk;

    pix_coord_t a_x, a_y, b_x, b_y;
    logic       a_blank, a_hs, a_vs, a_fs, a_ls;
    logic       b_blank, b_hs, b_vs, b_fs, b_ls;
    tg_state_e  a_st, b_st;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] a_fc, b_fc;
`endif

    int checks   = 0;
    int failures = 0;

    vga_timing_gen u_dut (
        .vga_clk     (vga_clk),
        .reset_n     (rst_a),
        .DrawX       (a_x),
        .DrawY       (a_y),
        .blank       (a_blank),
        .hs          (a_hs),
        .vs          (a_vs),
        .frame_start (a_fs),
        .line_start  (a_ls),
        .state_dbg   (a_st)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count (a_fc)
`endif
    );

    // 15 clocks per line, 8 lines per frame -> 120 clocks per frame
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_DLY (1)
    ) u_small (
        .vga_clk     (vga_clk),
        .reset_n     (rst_b),
        .DrawX       (b_x),
        .DrawY       (b_y),
        .blank       (b_blank),
        .hs          (b_hs),
        .vs          (b_vs),
        .frame_start (b_fs),
        .line_start  (b_ls),
        .state_dbg   (b_st)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count (b_fc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic wait_a(input int x, input int y, input int budget, input string tag);
        int n;
        n = 0;
        while (!(int'(a_x) == x && int'(a_y) == y) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(int'(a_x) == x && int'(a_y) == y), 32'd1);
    endtask

    task automatic wait_b(input int x, input int y, input int budget, input string tag);
        int n;
        n = 0;
        while (!(int'(b_x) == x && int'(b_y) == y) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(int'(b_x) == x && int'(b_y) == y), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int blank_n, ls_n, hs_n, hs_first, hs_last;
        int vs_n, vs_fx, vs_fy, fs_at;

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) tick();

        // Reset values
        check("rst_x",     32'(a_x),     32'd0);
        check("rst_y",     32'(a_y),     32'd0);
        check("rst_blank", 32'(a_blank), 32'd0);
        check("rst_hs",    32'(a_hs),    32'd1);
        check("rst_vs",    32'(a_vs),    32'd1);
        check("rst_fs",    32'(a_fs),    32'd0);
        check("rst_ls",    32'(a_ls),    32'd0);
        check("rst_state", 32'(a_st),    32'(HOLD));

        // Release: START shows pixel (0,0), then counting begins
        @(negedge vga_clk);
        rst_a = 1'b1;
        tick();
        check("start_x",     32'(a_x),     32'd0);
        check("start_y",     32'(a_y),     32'd0);
        check("start_blank", 32'(a_blank), 32'd1);
        check("start_fs",    32'(a_fs),    32'd1);
        check("start_ls",    32'(a_ls),    32'd1);
        check("start_state", 32'(a_st),    32'(START));
        tick();
        check("run1_x",     32'(a_x),  32'd1);
        check("run1_y",     32'(a_y),  32'd0);
        check("run1_fs",    32'(a_fs), 32'd0);
        check("run1_ls",    32'(a_ls), 32'd0);
        check("run1_state", 32'(a_st), 32'(RUN));

        // One full default line
        wait_a(0, 1, 1000, "wait_line1");
        blank_n = 0; ls_n = 0; hs_n = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (a_blank) blank_n++;
            if (a_ls) ls_n++;
            if (!a_hs) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(a_x);
                hs_last = int'(a_x);
            end
            tick();
        end
        check("line_blank_cnt", 32'(blank_n),  32'd640);
        check("line_ls_cnt",    32'(ls_n),     32'd1);
        check("line_hs_cnt",    32'(hs_n),     32'd96);
        check("line_hs_first",  32'(hs_first), 32'd657);
        check("line_hs_last",   32'(hs_last),  32'd752);
        check("line_next_x",    32'(a_x),      32'd0);
        check("line_next_y",    32'(a_y),      32'd2);
        check("line_next_ls",   32'(a_ls),     32'd1);

        // Reduced-timing instance: frame period and vsync window
        @(negedge vga_clk);
        rst_b = 1'b1;
        tick();
        check("b_start_fs", 32'(b_fs), 32'd1);
        check("b_start_x",  32'(b_x),  32'd0);
        vs_n = 0; vs_fx = -1; vs_fy = -1; fs_at = -1;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (k == 1) begin
                check("b_run1_x",  32'(b_x),  32'd1);
                check("b_run1_fs", 32'(b_fs), 32'd0);
            end
            if (!b_vs) begin
                vs_n++;
                if (vs_fx < 0) begin
                    vs_fx = int'(b_x);
                    vs_fy = int'(b_y);
                end
            end
            if (b_fs && fs_at < 0) fs_at = k;
        end
        check("b_fs_period", 32'(fs_at), 32'd120);
        check("b_vs_cnt",    32'(vs_n),  32'd30);
        check("b_vs_first_x", 32'(vs_fx), 32'd1);
        check("b_vs_first_y", 32'(vs_fy), 32'd5);

        // Frame wrap
        wait_b(14, 7, 200, "wait_wrap");
        tick();
        check("wrap_x",  32'(b_x),  32'd0);
        check("wrap_y",  32'(b_y),  32'd0);
        check("wrap_fs", 32'(b_fs), 32'd1);
        check("wrap_ls", 32'(b_ls), 32'd1);

        // Mid-frame asynchronous reset while both syncs are low
        wait_b(12, 6, 200, "wait_midframe");
        check("pre_rst_hs", 32'(b_hs), 32'd0);
        check("pre_rst_vs", 32'(b_vs), 32'd0);
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_rst_x",     32'(b_x),     32'd0);
        check("mid_rst_y",     32'(b_y),     32'd0);
        check("mid_rst_blank", 32'(b_blank), 32'd0);
        check("mid_rst_hs",    32'(b_hs),    32'd1);
        check("mid_rst_vs",    32'(b_vs),    32'd1);
        check("mid_rst_fs",    32'(b_fs),    32'd0);
        check("mid_rst_ls",    32'(b_ls),    32'd0);
        repeat (3) tick();
        @(negedge vga_clk);
        rst_b = 1'b1;
        tick();
        check("restart_x",     32'(b_x),     32'd0);
        check("restart_y",     32'(b_y),     32'd0);
        check("restart_blank", 32'(b_blank), 32'd1);
        check("restart_fs",    32'(b_fs),    32'd1);
        tick();
        check("restart_run_x", 32'(b_x), 32'd1);

`ifdef VGA_FRAME_COUNTER_EN
        check("fc_first", 32'(b_fc), 32'd0);
        repeat (3 * 120 - 1) tick();
        check("fc3_fs", 32'(b_fs), 32'd1);
        check("fc3",    32'(b_fc), 32'd3);
        repeat (253 * 120) tick();
        check("fc256_fs", 32'(b_fs), 32'd1);
        check("fc256",    32'(b_fc), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
